deser_rr_ctrl: RTL

- Round-robin controller that shares one serial-to-parallel deserializer among N serial requesters.
- Grants one requester at a time for exactly one word of DESER_W bits and steers that requester's bit stream into the deserializer.
- Waits for the deserializer's parallel result, then returns the word tagged with the source index.
- Sits between N serial sources and a single deserializer instance; a timeout guards against a missing result.

---
 rtl/deser_rr_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/deser_rr_ctrl.sv
// Round-robin controller that shares one serial-to-parallel deserializer among N serial lanes.
// One lane is granted per word; the parallel result is returned tagged with its source index.
module deser_rr_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned DESER_W = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ID_W    = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N-1:0]       req_i,
    input  logic [N-1:0]       data_val_i,
    input  logic [N-1:0]       data_i,
    output logic [N-1:0]       gnt_o,
    output logic               ser_data_o,
    output logic               ser_data_val_o,
    input  logic [DESER_W-1:0] deser_data_i,
    input  logic               deser_data_val_i,
    output logic [DESER_W-1:0] word_o,
    output logic [ID_W-1:0]    word_id_o,
    output logic               word_val_o,
    output logic               timeout_o,
    output logic               busy_o
);

    localparam int unsigned CntW = (DESER_W > 1) ? $clog2(DESER_W) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StWait} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [DESER_W-1:0] word_q, word_d;
    logic [ID_W-1:0]    word_id_q, word_id_d;
    logic               word_val_q, word_val_d;
    logic               timeout_q, timeout_d;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;

    // Scan from the farthest offset down so the lane closest after the pointer wins.
    always_comb begin
        winner = ptr_q;
        cand   = ptr_q;
        for (int unsigned off = N; off > 0; off--) begin
            cand = ID_W'((ptr_q + off) % N);
            if (req_i[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        gnt_d          = gnt_q;
        bit_cnt_d      = bit_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        word_d         = word_q;
        word_id_d      = word_id_q;
        word_val_d     = 1'b0;
        timeout_d      = 1'b0;
        ser_data_val_o = 1'b0;
        ser_data_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    ptr_d         = winner;
                    id_d          = winner;
                    state_d       = StStream;
                end
            end
            StStream: begin
                ser_data_val_o = data_val_i[id_q];
                ser_data_o     = data_val_i[id_q] & data_i[id_q];
                if (data_val_i[id_q]) begin
                    if (bit_cnt_q == CntW'(DESER_W - 1)) begin
                        bit_cnt_d  = '0;
                        wait_cnt_d = '0;
                        gnt_d      = '0;
                        state_d    = StWait;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StWait: begin
                // A result arriving on the last allowed cycle beats the timeout.
                if (deser_data_val_i) begin
                    word_d     = deser_data_i;
                    word_id_d  = id_q;
                    word_val_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    word_id_d  = id_q;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            ptr_q      <= ID_W'(N - 1);
            id_q       <= '0;
            gnt_q      <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            word_q     <= '0;
            word_id_q  <= '0;
            word_val_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            gnt_q      <= gnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            word_id_q  <= word_id_d;
            word_val_q <= word_val_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign word_o     = word_q;
    assign word_id_o  = word_id_q;
    assign word_val_o = word_val_q;
    assign timeout_o  = timeout_q;
    assign busy_o     = (state_q != StIdle);

endmodule
